cr16_control_fsm: RTL and testbench

Instruction sequencer that drives the register-bank/ALU datapath: write enables, ALU opcode, register selects, immediate and immediate select.
- Fetches 16-bit instructions over a valid/ready handshake and holds the program counter.
- Decodes CR16-style fields and pulses exactly one register write per ALU instruction.
- Latches ALU flags and resolves conditional branches.

---
 rtl/cr16_pkg.sv | 102 ++++++++++
 rtl/cr16_control_fsm_branch_cond_eval.sv | 33 +++
 rtl/cr16_control_fsm.sv | 165 ++++++++++++++++
 tb/tb_cr16_control_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared encodings, flag indices, FSM states and the instruction decoder
// used by the CR16 control sequencer.
package cr16_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LSH  = 4'b0100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       branch;
    logic       wr;
    logic       upd_flags;
    logic       imm_sel;
    logic [7:0] opcode;
  } dec_t;

  // The ALU codes appear both as R-type ext and as I-type op.
  function automatic logic is_alu_code(input logic [3:0] c);
    return (c == OP_ADD) || (c == OP_SUB) || (c == OP_CMP) || (c == OP_AND) ||
           (c == OP_OR)  || (c == OP_XOR) || (c == OP_MOV);
  endfunction

  function automatic logic is_arith(input logic [3:0] c);
    return (c == OP_ADD) || (c == OP_SUB) || (c == OP_CMP);
  endfunction

  function automatic dec_t decode(input logic [15:0] ins);
    dec_t       d;
    logic [3:0] op;
    logic [3:0] ext;
    op        = ins[15:12];
    ext       = ins[7:4];
    d         = '0;
    d.imm_sel = 1'b1;
    case (op)
      OP_RTYPE: begin
        if (is_alu_code(ext)) begin
          d.legal     = 1'b1;
          d.wr        = (ext != OP_CMP);
          d.upd_flags = is_arith(ext);
          d.opcode    = {4'b0000, ext};
        end
      end
      OP_SHIFT: begin
        if (ext == EXT_LSH) begin
          d.legal  = 1'b1;
          d.wr     = 1'b1;
          d.opcode = {OP_SHIFT, EXT_LSH};
        end
      end
      OP_BCOND: begin
        d.legal  = 1'b1;
        d.branch = 1'b1;
      end
      default: begin
        if (is_alu_code(op)) begin
          d.legal     = 1'b1;
          d.wr        = (op != OP_CMP);
          d.upd_flags = is_arith(op);
          d.imm_sel   = 1'b0;
          d.opcode    = {op, 4'b0000};
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cr16_control_fsm_branch_cond_eval.sv
// Combinational branch resolver: condition code against the latched flags.
// Undefined codes are simply never taken.
module branch_cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  // F carries no branch meaning; it is kept in the port so callers pass the whole register.
  logic unused_flag_f;
  assign unused_flag_f = flags[FLAG_F];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flags[FLAG_Z];
      COND_NE: taken = ~flags[FLAG_Z];
      COND_CS: taken = flags[FLAG_C];
      COND_CC: taken = ~flags[FLAG_C];
      COND_HI: taken = flags[FLAG_L];
      COND_LS: taken = ~flags[FLAG_L];
      COND_GT: taken = flags[FLAG_N];
      COND_LE: taken = ~flags[FLAG_N];
      COND_LT: taken = ~flags[FLAG_N] & ~flags[FLAG_Z];
      COND_GE: taken = flags[FLAG_N] | flags[FLAG_Z];
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr16_control_fsm.sv
// CR16 instruction sequencer: FETCH -> DECODE -> EXEC, 3 cycles per instruction,
// register write 2 edges after accept; instr_ready only in FETCH, stalls while instr_valid is low.
module cr16_control_fsm
  import cr16_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [PC_WIDTH-1:0] pc,
  input  logic [4:0]          Flags_in,
  output logic [15:0]         wEnable,
  output logic [7:0]          opcode,
  output logic [3:0]          Rdest_select,
  output logic [3:0]          Rsrc_select,
  output logic                Imm_select,
  output logic [15:0]         Imm_in,
  output logic [4:0]          flags_q,
  output logic                illegal
);

  state_e              state_q, state_d;
  logic                run_q;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [4:0]          flg_q, flg_d;
  logic [15:0]         wen_q, wen_d;
  logic                ill_q, ill_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [3:0]          rdest_q, rdest_d;
  logic [3:0]          rsrc_q, rsrc_d;
  logic                imm_sel_q, imm_sel_d;
  logic [15:0]         imm_q, imm_d;
  logic [7:0]          disp_q, disp_d;
  logic                legal_q, legal_d;
  logic                branch_q, branch_d;
  logic                wr_q, wr_d;
  logic                upd_q, upd_d;

  dec_t                dec_in;
  logic                accept;
  logic                taken;
  logic [PC_WIDTH-1:0] disp_ext;

  assign dec_in      = decode(instr);
  assign instr_ready = run_q && (state_q == FETCH);
  assign accept      = instr_ready && instr_valid;
  assign disp_ext    = PC_WIDTH'($signed(disp_q));

  // rd doubles as the condition field of a branch.
  branch_cond_eval u_branch_cond_eval (
    .cond  (rdest_q),
    .flags (flg_q),
    .taken (taken)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flg_d     = flg_q;
    wen_d     = '0;
    ill_d     = 1'b0;
    opcode_d  = opcode_q;
    rdest_d   = rdest_q;
    rsrc_d    = rsrc_q;
    imm_sel_d = imm_sel_q;
    imm_d     = imm_q;
    disp_d    = disp_q;
    legal_d   = legal_q;
    branch_d  = branch_q;
    wr_d      = wr_q;
    upd_d     = upd_q;
    case (state_q)
      FETCH: begin
        if (accept) begin
          state_d  = DECODE;
          rdest_d  = instr[11:8];
          rsrc_d   = instr[3:0];
          disp_d   = instr[7:0];
          legal_d  = dec_in.legal;
          branch_d = dec_in.branch;
          wr_d     = dec_in.wr;
          upd_d    = dec_in.upd_flags;
          // Branches and illegal words leave the ALU-facing controls untouched.
          if (dec_in.legal && !dec_in.branch) begin
            opcode_d  = dec_in.opcode;
            imm_sel_d = dec_in.imm_sel;
            imm_d     = 16'($signed(instr[7:0]));
          end
        end
      end
      DECODE: begin
        state_d = EXEC;
        if (wr_q) begin
          wen_d = 16'h0001 << rdest_q;
        end
        ill_d = ~legal_q;
      end
      EXEC: begin
        state_d = FETCH;
        if (upd_q) begin
          flg_d = Flags_in;
        end
        if (branch_q && taken) begin
          pc_d = pc_q + disp_ext;
        end else begin
          pc_d = pc_q + PC_WIDTH'(1);
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      run_q     <= 1'b0;
      pc_q      <= RESET_PC;
      flg_q     <= '0;
      wen_q     <= '0;
      ill_q     <= 1'b0;
      opcode_q  <= '0;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      imm_sel_q <= 1'b1;
      imm_q     <= '0;
      disp_q    <= '0;
      legal_q   <= 1'b0;
      branch_q  <= 1'b0;
      wr_q      <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      pc_q      <= pc_d;
      flg_q     <= flg_d;
      wen_q     <= wen_d;
      ill_q     <= ill_d;
      opcode_q  <= opcode_d;
      rdest_q   <= rdest_d;
      rsrc_q    <= rsrc_d;
      imm_sel_q <= imm_sel_d;
      imm_q     <= imm_d;
      disp_q    <= disp_d;
      legal_q   <= legal_d;
      branch_q  <= branch_d;
      wr_q      <= wr_d;
      upd_q     <= upd_d;
    end
  end

  assign pc           = pc_q;
  assign flags_q      = flg_q;
  assign wEnable      = wen_q;
  assign illegal      = ill_q;
  assign opcode       = opcode_q;
  assign Rdest_select = rdest_q;
  assign Rsrc_select  = rsrc_q;
  assign Imm_select   = imm_sel_q;
  assign Imm_in       = imm_q;

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Table-driven, scoreboarded bench for the CR16 control sequencer.
module tb_cr16_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic [4:0]  Flags_in;
  logic [15:0] wEnable;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_select;
  logic [3:0]  Rsrc_select;
  logic        Imm_select;
  logic [15:0] Imm_in;
  logic [4:0]  flags_q;
  logic        illegal;

  always #5 clk = ~clk;

  cr16_control_fsm #(
    .PC_WIDTH (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .Flags_in     (Flags_in),
    .wEnable      (wEnable),
    .opcode       (opcode),
    .Rdest_select (Rdest_select),
    .Rsrc_select  (Rsrc_select),
    .Imm_select   (Imm_select),
    .Imm_in       (Imm_in),
    .flags_q      (flags_q),
    .illegal      (illegal)
  );

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  fin;
    bit          chk_dec;
    bit          chk_imm;
    logic [7:0]  opc;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        isel;
    logic [15:0] imm;
    logic [15:0] wen;
    logic        ill;
    logic [4:0]  flags;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [15:0] i, input logic [4:0] f, input bit cd, input bit ci,
                              input logic [7:0] o, input logic [3:0] rd, input logic [3:0] rs,
                              input logic is, input logic [15:0] im, input logic [15:0] wen,
                              input logic il, input logic [4:0] fl, input logic [15:0] p);
    vec_t v;
    v.instr = i;  v.fin = f;   v.chk_dec = cd; v.chk_imm = ci;
    v.opc = o;    v.rd = rd;   v.rs = rs;      v.isel = is;
    v.imm = im;   v.wen = wen; v.ill = il;     v.flags = fl;   v.pc = p;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   w;
    sb.push_back(v);
    instr       = v.instr;
    Flags_in    = v.fin;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_ready", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    e = sb.pop_front();
    // Garbage offered during DECODE/EXEC must be ignored.
    instr = 16'($urandom);
    chk("dec_ready", 32'(instr_ready), 32'd0);
    chk("dec_wen", 32'(wEnable), 32'd0);
    chk("dec_ill", 32'(illegal), 32'd0);
    if (e.chk_dec) begin
      chk("dec_opcode", 32'(opcode), 32'(e.opc));
      chk("dec_rdest", 32'(Rdest_select), 32'(e.rd));
      chk("dec_rsrc", 32'(Rsrc_select), 32'(e.rs));
      chk("dec_isel", 32'(Imm_select), 32'(e.isel));
      if (e.chk_imm) chk("dec_imm", 32'(Imm_in), 32'(e.imm));
    end
    @(posedge clk); #1;
    chk("exec_wen", 32'(wEnable), 32'(e.wen));
    chk("exec_ill", 32'(illegal), 32'(e.ill));
    if (e.chk_dec) chk("exec_opcode_hold", 32'(opcode), 32'(e.opc));
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("pc", 32'(pc), 32'(e.pc));
    chk("flags", 32'(flags_q), 32'(e.flags));
    chk("post_wen", 32'(wEnable), 32'd0);
    chk("post_ill", 32'(illegal), 32'd0);
    chk("post_ready", 32'(instr_ready), 32'd1);
    Flags_in = 5'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //           instr     Fin       dec ci  opc    rd    rs    is    imm        wen        il    flags     pc
    vecs.push_back(mk(16'h5305, 5'b00010, 1, 1, 8'h50, 4'h3, 4'h5, 1'b0, 16'h0005, 16'h0008, 1'b0, 5'b00010, 16'h0001));
    vecs.push_back(mk(16'h01B2, 5'b00010, 1, 0, 8'h0B, 4'h1, 4'h2, 1'b1, 16'h0000, 16'h0000, 1'b0, 5'b00010, 16'h0002));
    vecs.push_back(mk(16'h9204, 5'b10001, 1, 1, 8'h90, 4'h2, 4'h4, 1'b0, 16'h0004, 16'h0004, 1'b0, 5'b10001, 16'h0003));
    vecs.push_back(mk(16'h0413, 5'b11111, 1, 0, 8'h01, 4'h4, 4'h3, 1'b1, 16'h0000, 16'h0010, 1'b0, 5'b10001, 16'h0004));
    vecs.push_back(mk(16'hB7FF, 5'b00010, 1, 1, 8'hB0, 4'h7, 4'hF, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 5'b00010, 16'h0005));
    vecs.push_back(mk(16'hC0FC, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00010, 16'h0001));
    vecs.push_back(mk(16'h8A46, 5'b11111, 1, 0, 8'h84, 4'hA, 4'h6, 1'b1, 16'h0000, 16'h0400, 1'b0, 5'b00010, 16'h0002));
    vecs.push_back(mk(16'hF000, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b1, 5'b00010, 16'h0003));
    vecs.push_back(mk(16'h5200, 5'b00000, 1, 1, 8'h50, 4'h2, 4'h0, 1'b0, 16'h0000, 16'h0004, 1'b0, 5'b00000, 16'h0004));
    vecs.push_back(mk(16'h0DD5, 5'b11111, 1, 0, 8'h0D, 4'hD, 4'h5, 1'b1, 16'h0000, 16'h2000, 1'b0, 5'b00000, 16'h0005));
    vecs.push_back(mk(16'hC0FC, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00000, 16'h0006));
    vecs.push_back(mk(16'hC1FC, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00000, 16'h0002));
    vecs.push_back(mk(16'hCAFF, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00000, 16'h0003));
    vecs.push_back(mk(16'hCEED, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00000, 16'hFFF0));
    vecs.push_back(mk(16'hCE7F, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00000, 16'h006F));
    vecs.push_back(mk(16'h3FFF, 5'b11111, 1, 1, 8'h30, 4'hF, 4'hF, 1'b0, 16'hFFFF, 16'h8000, 1'b0, 5'b00000, 16'h0070));
    vecs.push_back(mk(16'h0E23, 5'b11111, 1, 0, 8'h02, 4'hE, 4'h3, 1'b1, 16'h0000, 16'h4000, 1'b0, 5'b00000, 16'h0071));
    vecs.push_back(mk(16'h0000, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b1, 5'b00000, 16'h0072));
    vecs.push_back(mk(16'hCC01, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00000, 16'h0073));
    vecs.push_back(mk(16'hCD05, 5'b11111, 0, 0, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00000, 16'h0074));

    // Reset held with a valid instruction on the bus.
    reset       = 1'b0;
    instr       = 16'h5305;
    instr_valid = 1'b1;
    Flags_in    = 5'b11111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_wen", 32'(wEnable), 32'h0);
    chk("rst_ready", 32'(instr_ready), 32'h0);
    chk("rst_flags", 32'(flags_q), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_rdest", 32'(Rdest_select), 32'h0);
    chk("rst_rsrc", 32'(Rsrc_select), 32'h0);
    chk("rst_isel", 32'(Imm_select), 32'h1);
    chk("rst_imm", 32'(Imm_in), 32'h0);
    chk("rst_ill", 32'(illegal), 32'h0);
    instr_valid = 1'b0;
    reset       = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 32'(instr_ready), 32'h1);
    chk("rel_pc", 32'(pc), 32'h0);

    foreach (vecs[k]) begin
      repeat ($urandom_range(0, 2)) begin
        instr = 16'($urandom);
        @(posedge clk); #1;
      end
      run_vec(vecs[k]);
    end

    // Long stall with a changing bus and valid low.
    for (int c = 0; c < 10; c++) begin
      instr = 16'($urandom);
      @(posedge clk); #1;
      chk("idle_pc", 32'(pc), 32'h0074);
      chk("idle_ready", 32'(instr_ready), 32'h1);
      chk("idle_wen", 32'(wEnable), 32'h0);
    end

    // Reset arriving while ADD R1,R2 sits in DECODE.
    instr       = 16'h0152;
    Flags_in    = 5'b11111;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_in_decode", 32'(instr_ready), 32'h0);
    reset       = 1'b0;
    instr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("mid_wen", 32'(wEnable), 32'h0);
      chk("mid_pc", 32'(pc), 32'h0);
      chk("mid_flags", 32'(flags_q), 32'h0);
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_mid_wen", 32'(wEnable), 32'h0);
      chk("post_mid_ready", 32'(instr_ready), 32'h1);
    end
    run_vec(mk(16'h5305, 5'b00010, 1, 1, 8'h50, 4'h3, 4'h5, 1'b0, 16'h0005, 16'h0008, 1'b0, 5'b00010, 16'h0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
